// File: rtl/mux_select_pipe.sv
// Registered N:1 word multiplexer with optional per-transfer bitwise inversion,
// one output stage behind a valid/ready handshake, sticky bad-select flag and transfer counter.
module mux_select_pipe #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [N_CH*W-1:0] up_data,
  input  logic [SEL_W-1:0]  up_sel,
  input  logic              up_inv,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [W-1:0]      down_data,
  output logic [SEL_W-1:0]  down_ch,
  output logic              err_sel,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Handshake: a side moves a word only on a rising edge where its valid and
  // ready are both high; valid never waits for ready, and a held result stays
  // stable until it is taken.
  logic             accept, xfer, sel_ok;
  logic [W-1:0]     word, result;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign up_ready = !valid_q || down_ready;
  assign accept   = up_valid && up_ready;
  assign xfer     = valid_q && down_ready;

  // A select matching no channel yields zero and flags itself via sel_ok.
  always_comb begin
    word   = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (up_sel == SEL_W'(k)) begin
        word   = up_data[k*W +: W];
        sel_ok = 1'b1;
      end
    end
    result = up_inv ? ~word : word;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = result;
      ch_d    = up_sel;
      if (!sel_ok) err_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign down_valid = valid_q;
  assign down_data  = data_q;
  assign down_ch    = ch_q;
  assign err_sel    = err_q;
  assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_mux_select_pipe.sv
// Directed bench for mux_select_pipe: a 4-channel instance for the main datapath
// and a 3-channel, 4-bit-counter instance for bad selects and counter wrap.
module tb_mux_select_pipe;

  logic clk, rst_n;

  logic        up_valid, up_ready, up_inv, down_valid, down_ready, err_sel;
  logic [31:0] up_data;
  logic [1:0]  up_sel, down_ch;
  logic [7:0]  down_data;
  logic [15:0] xfer_cnt;

  logic        up_valid3, up_ready3, up_inv3, down_valid3, down_ready3, err_sel3;
  logic [23:0] up_data3;
  logic [1:0]  up_sel3, down_ch3;
  logic [7:0]  down_data3;
  logic [3:0]  xfer_cnt3;

  int n_checks, n_pass;
  logic [7:0]  exp_plain [4];
  logic [7:0]  exp_inv   [4];
  logic [15:0] cnt_base;

  mux_select_pipe #(.N_CH(4), .W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_sel(up_sel), .up_inv(up_inv),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
    .down_ch(down_ch), .err_sel(err_sel), .xfer_cnt(xfer_cnt)
  );

  mux_select_pipe #(.N_CH(3), .W(8), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid3), .up_ready(up_ready3), .up_data(up_data3),
    .up_sel(up_sel3), .up_inv(up_inv3),
    .down_valid(down_valid3), .down_ready(down_ready3), .down_data(down_data3),
    .down_ch(down_ch3), .err_sel(err_sel3), .xfer_cnt(xfer_cnt3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic inv);
    up_valid = 1'b1;
    up_sel   = sel;
    up_inv   = inv;
  endtask

  task automatic drive3(input logic [1:0] sel, input logic inv);
    up_valid3 = 1'b1;
    up_sel3   = sel;
    up_inv3   = inv;
  endtask

  initial begin
    exp_plain = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_inv   = '{8'h55, 8'h44, 8'h33, 8'h22};
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    up_valid = 1'b0; up_data = 32'hDDCCBBAA; up_sel = 2'd0; up_inv = 1'b0; down_ready = 1'b1;
    up_valid3 = 1'b0; up_data3 = 24'hCCBBAA; up_sel3 = 2'd0; up_inv3 = 1'b0; down_ready3 = 1'b1;
    step();
    step();
    check("rst_valid", down_valid, 0);
    check("rst_data", down_data, 0);
    check("rst_cnt", xfer_cnt, 0);
    check("rst_err", err_sel, 0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", up_ready, 1);

    // basic select
    drive(2'd2, 1'b0);
    step();
    up_valid = 1'b0;
    check("basic_valid", down_valid, 1);
    check("basic_data", down_data, 8'hCC);
    check("basic_ch", down_ch, 2);
    step();
    check("basic_cnt", xfer_cnt, 1);
    check("basic_drain", down_valid, 0);

    // every channel plain and inverted
    for (int ch = 0; ch < 4; ch++) begin
      for (int inv = 0; inv < 2; inv++) begin
        drive(2'(ch), 1'(inv));
        step();
        up_valid = 1'b0;
        check($sformatf("inv_ch%0d_i%0d", ch, inv), down_data,
              (inv != 0) ? exp_inv[ch] : exp_plain[ch]);
        step();
      end
    end
    check("inv_cnt", xfer_cnt, 9);

    // backpressure
    down_ready = 1'b0;
    drive(2'd1, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      up_valid = 1'b1;
      up_data  = $urandom_range(0, 32'h7fffffff);
      up_sel   = 2'($urandom_range(0, 3));
      up_inv   = 1'($urandom_range(0, 1));
      step();
      check("bp_ready", up_ready, 0);
      check("bp_data", down_data, 8'hBB);
      check("bp_ch", down_ch, 1);
      check("bp_cnt", xfer_cnt, 9);
    end
    up_valid = 1'b0;
    up_data  = 32'hDDCCBBAA;
    down_ready = 1'b1;
    #1;
    check("bp_release_ready", up_ready, 1);
    step();
    check("bp_release_cnt", xfer_cnt, 10);
    check("bp_release_valid", down_valid, 0);

    // back-to-back streaming
    cnt_base = xfer_cnt;
    for (int i = 0; i < 10; i++) begin
      drive(2'(i % 4), 1'b0);
      step();
      check("stream_valid", down_valid, 1);
      check($sformatf("stream_data%0d", i), down_data, exp_plain[i % 4]);
    end
    up_valid = 1'b0;
    step();
    check("stream_cnt", xfer_cnt - cnt_base, 10);
    check("pow2_err", err_sel, 0);

    // reset with a result in flight
    down_ready = 1'b0;
    drive(2'd3, 1'b1);
    step();
    up_valid = 1'b0;
    check("inflight_valid", down_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", down_valid, 0);
    check("async_data", down_data, 0);
    check("async_ch", down_ch, 0);
    check("async_cnt", xfer_cnt, 0);
    check("async_err", err_sel, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", up_ready, 1);
    down_ready = 1'b1;
    drive(2'd2, 1'b1);
    step();
    up_valid = 1'b0;
    check("post_rst_data", down_data, 8'h33);
    step();
    check("post_rst_cnt", xfer_cnt, 1);

    // 3-channel instance: counter wrap over 17 transfers
    check("n3_rst_err", err_sel3, 0);
    for (int i = 0; i < 17; i++) begin
      drive3(2'(i % 3), 1'b0);
      step();
    end
    up_valid3 = 1'b0;
    step();
    check("wrap_cnt", xfer_cnt3, 1);
    check("wrap_err", err_sel3, 0);

    // bad select while blocked is not accepted
    down_ready3 = 1'b0;
    drive3(2'd1, 1'b0);
    step();
    drive3(2'd3, 1'b1);
    step();
    step();
    check("blocked_err", err_sel3, 0);
    check("blocked_data", down_data3, 8'hBB);
    up_valid3 = 1'b0;
    down_ready3 = 1'b1;
    step();

    // accepted bad select
    drive3(2'd3, 1'b1);
    step();
    up_valid3 = 1'b0;
    check("oor_data_inv", down_data3, 8'hFF);
    check("oor_ch", down_ch3, 3);
    check("oor_err", err_sel3, 1);
    step();
    drive3(2'd3, 1'b0);
    step();
    up_valid3 = 1'b0;
    check("oor_data_plain", down_data3, 8'h00);
    drive3(2'd0, 1'b0);
    step();
    drive3(2'd2, 1'b1);
    step();
    up_valid3 = 1'b0;
    check("oor_next_data", down_data3, 8'h33);
    step();
    check("oor_sticky", err_sel3, 1);
    check("n3_cnt", xfer_cnt3, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_select_pipe.md
Name: mux_select_pipe

Overview:
- Parametrised, registered N:1 word multiplexer with an optional per-transfer bitwise inversion mode.
- Bit-level behaviour matches the codebase's mux primitives: inversion is a per-bit select between d and ~d.
- Sits between producer and consumer datapaths behind a valid/ready handshake, with one output register stage and backpressure.
- Flags out-of-range selects and counts completed transfers for debug.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel in bits (1..64).
- SEL_W, $clog2(N_CH), width of the channel select field.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_valid  input  1  upstream request valid.
- up_ready  output  1  block can accept a request this cycle.
- up_data  input  N_CH*W  flattened channels; channel k occupies bits [k*W +: W].
- up_sel  input  SEL_W  channel to forward.
- up_inv  input  1  1 = forward bitwise inverse of the selected channel.
- down_valid  output  1  output register holds a valid result.
- down_ready  input  1  downstream accepts the result.
- down_data  output  W  selected (optionally inverted) word.
- down_ch  output  SEL_W  channel index that produced down_data.
- err_sel  output  1  sticky; set when an accepted request had up_sel >= N_CH.
- xfer_cnt  output  CNT_W  number of completed downstream transfers.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately without a clock):
  - down_valid=0, down_data=0, down_ch=0, err_sel=0, xfer_cnt=0.
  - up_ready=1 once rst_n is high; it follows the combinational rule below.
- Handshake:
  - up_ready = !down_valid || down_ready (combinational; single output register, no skid buffer).
  - Accept occurs when up_valid && up_ready on a rising edge.
  - Downstream transfer occurs when down_valid && down_ready.
- Datapath, computed on accept:
  - sel_ok = (up_sel < N_CH).
  - word = sel_ok ? up_data[up_sel*W +: W] : {W{1'b0}}.
  - down_data <= up_inv ? ~word : word; down_ch <= up_sel.
  - Out-of-range select still produces a result: data is 0, or all-ones when up_inv=1. It also sets err_sel.
- Latency: exactly 1 cycle from accept to down_valid=1.
- Throughput: 1 transfer/cycle while down_ready is held high.
- Output register update rules:
  - accept: down_valid <= 1; data and ch load.
  - transfer without accept: down_valid <= 0; data and ch hold their last value.
  - transfer and accept in the same cycle: new data loads and down_valid stays 1. This is the back-to-back case.
  - down_valid=1 && down_ready=0: down_data and down_ch are stable. up_ready=0, so up_valid is ignored.
- err_sel:
  - Set on any accept with !sel_ok.
  - Cleared only by reset.
  - Never set by unaccepted requests.
- xfer_cnt:
  - Increments by 1 per downstream transfer.
  - Wraps from 2^CNT_W-1 to 0 without saturating.
- up_data, up_sel and up_inv are sampled only on accept. Changes while up_ready=0 have no effect.
- Reset asserted mid-transfer: the in-flight result is discarded and is not counted. After reset the first accept behaves as from idle.
- When N_CH is a power of two, sel_ok is always 1 and err_sel stays 0.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-simulation while down_valid=1.
  - Required: down_valid, down_data, err_sel and xfer_cnt go to 0 immediately, before the next clock edge. up_ready=1 after release.
- Basic select (N_CH=4, W=8):
  - Stimulus: up_data={8'hDD,8'hCC,8'hBB,8'hAA}, up_sel=2, up_inv=0, down_ready=1.
  - Required: next cycle down_valid=1, down_data=8'hCC, down_ch=2, xfer_cnt=1.
- Inversion:
  - Stimulus: same data, up_sel=0, up_inv=1.
  - Required: down_data=8'h55. Repeat for each channel with inv=0 and inv=1 (8 results, all correct).
- Backpressure:
  - Stimulus: accept sel=1, hold down_ready=0 for 5 cycles while changing up_data/up_sel.
  - Required: up_ready=0, down_data=8'hBB stable throughout, xfer_cnt unchanged. Raising down_ready gives one transfer.
- Back-to-back streaming:
  - Stimulus: up_valid=1 and down_ready=1 for 10 cycles, sel cycling 0..3.
  - Required: one result per cycle in order, no bubbles, xfer_cnt=10.
- Out-of-range and wrap:
  - Stimulus: with N_CH=3, accept up_sel=3, up_inv=1.
  - Required: down_data=8'hFF, err_sel=1 and sticky after later valid requests.
  - Stimulus: with CNT_W=4, run 17 transfers.
  - Required: xfer_cnt=1.
